// File: rtl/sha256_core_multi.sv
// ============================================================================
// sha256_core_multi : SHA-256/SHA-224 compression engine, 1/2/4 rounds per clk
// Revision : 1.0
// ============================================================================
`default_nettype none

module sha256_core_multi #(
  parameter int ROUNDS_PER_CYCLE = 1,
  parameter int SUPPORT_224      = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         block_valid,
  output logic         block_ready,
  input  logic [511:0] block_in,
  input  logic         block_init,
  input  logic         block_last,
  input  logic         mode_224,
  input  logic         abort,
  output logic         digest_valid,
  input  logic         digest_ready,
  output logic [255:0] digest_out,
  output logic         busy
);

  generate
    if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 || ROUNDS_PER_CYCLE == 4)) begin : g_bad_rpc
      $error("sha256_core_multi: ROUNDS_PER_CYCLE must be 1, 2 or 4");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_COMP = 2'd1,
    S_FIN  = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  localparam logic [6:0] c_step = 7'(ROUNDS_PER_CYCLE);

  localparam logic [31:0] c_k [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [31:0] c_iv256 [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };
  localparam logic [31:0] c_iv224 [8] = '{
    32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
    32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
  };

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction
  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return ror(x, 2) ^ ror(x, 13) ^ ror(x, 22);
  endfunction
  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return ror(x, 6) ^ ror(x, 11) ^ ror(x, 25);
  endfunction
  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
  endfunction
  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
  endfunction

  state_t      r_state, w_state_nxt;
  logic [31:0] r_h   [8];
  logic [31:0] r_wv  [8];
  logic [31:0] r_buf [16];
  logic [6:0]  r_t;
  logic        r_last;
  logic        r_mode224;

  logic [31:0] w_nxt     [8];
  logic [31:0] w_buf_nxt [16];
  logic [6:0]  w_t;
  logic [31:0] w_w, w_t1, w_t2;
  logic        w_use224;

  assign w_use224 = mode_224 && (SUPPORT_224 != 0);

  // Rounds chained within one cycle; expanded words land in the buffer copy
  // immediately so a later round in the same cycle sees them.
  always_comb begin
    w_nxt     = r_wv;
    w_buf_nxt = r_buf;
    w_t       = r_t;
    w_w       = '0;
    w_t1      = '0;
    w_t2      = '0;
    for (int j = 0; j < ROUNDS_PER_CYCLE; j++) begin
      w_t = r_t + 7'(j);
      if (w_t < 7'd16) begin
        w_w = w_buf_nxt[w_t[3:0]];
      end else begin
        w_w = ssig1(w_buf_nxt[w_t[3:0] - 4'd2]) + w_buf_nxt[w_t[3:0] - 4'd7]
            + ssig0(w_buf_nxt[w_t[3:0] - 4'd15]) + w_buf_nxt[w_t[3:0]];
      end
      w_buf_nxt[w_t[3:0]] = w_w;
      w_t1 = w_nxt[7] + bsig1(w_nxt[4]) + ((w_nxt[4] & w_nxt[5]) ^ (~w_nxt[4] & w_nxt[6]))
           + c_k[w_t[5:0]] + w_w;
      w_t2 = bsig0(w_nxt[0]) + ((w_nxt[0] & w_nxt[1]) ^ (w_nxt[0] & w_nxt[2]) ^ (w_nxt[1] & w_nxt[2]));
      for (int i = 7; i > 0; i--) w_nxt[i] = w_nxt[i-1];
      w_nxt[4] = w_nxt[4] + w_t1;
      w_nxt[0] = w_t1 + w_t2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // COMP spends one extra cycle at t==64 before FIN, giving 64/R+2 latency.
  always_comb begin
    w_state_nxt  = r_state;
    block_ready  = 1'b0;
    digest_valid = 1'b0;
    busy         = 1'b1;
    case (r_state)
      S_IDLE: begin
        block_ready = 1'b1;
        busy        = 1'b0;
        if (block_valid) w_state_nxt = S_COMP;
      end
      S_COMP: if (r_t == 7'd64) w_state_nxt = S_FIN;
      S_FIN:  w_state_nxt = r_last ? S_OUT : S_IDLE;
      S_OUT: begin
        digest_valid = 1'b1;
        if (digest_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (abort) w_state_nxt = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        r_h[i]  <= '0;
        r_wv[i] <= '0;
      end
      for (int i = 0; i < 16; i++) r_buf[i] <= '0;
      r_t       <= '0;
      r_last    <= 1'b0;
      r_mode224 <= 1'b0;
    end else if (!abort) begin
      case (r_state)
        S_IDLE: if (block_valid) begin
          for (int i = 0; i < 16; i++) r_buf[i] <= block_in[511 - 32*i -: 32];
          for (int i = 0; i < 8; i++) begin
            if (block_init) begin
              r_h[i]  <= w_use224 ? c_iv224[i] : c_iv256[i];
              r_wv[i] <= w_use224 ? c_iv224[i] : c_iv256[i];
            end else begin
              r_wv[i] <= r_h[i];
            end
          end
          if (block_init) r_mode224 <= w_use224;
          r_last <= block_last;
          r_t    <= '0;
        end
        S_COMP: if (r_t != 7'd64) begin
          r_wv  <= w_nxt;
          r_buf <= w_buf_nxt;
          r_t   <= r_t + c_step;
        end
        S_FIN: for (int i = 0; i < 8; i++) r_h[i] <= r_h[i] + r_wv[i];
        default: ;
      endcase
    end
  end

  assign digest_out = {r_h[0], r_h[1], r_h[2], r_h[3], r_h[4], r_h[5], r_h[6],
                       r_mode224 ? 32'h0 : r_h[7]};

endmodule

`default_nettype wire

// File: tb/tb_sha256_core_multi.sv
// ============================================================================
// tb_sha256_core_multi : directed bench for sha256_core_multi at R = 1, 2, 4
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_sha256_core_multi;

  localparam logic [511:0] c_abc = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] c_two1 = {
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
    32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
    32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] c_two2 = {448'h0, 64'h1c0};
  localparam logic [255:0] c_d256 = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] c_d224 = 256'h23097d22_3405d822_8642a477_bda255b3_2aadbce4_bda0b3f7_e36c9da7_00000000;
  localparam logic [255:0] c_dtwo = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

  logic         clk;
  logic         rst_n;
  logic         block_valid  [3];
  logic         block_ready  [3];
  logic [511:0] block_in     [3];
  logic         block_init   [3];
  logic         block_last   [3];
  logic         mode_224     [3];
  logic         abort        [3];
  logic         digest_valid [3];
  logic         digest_ready [3];
  logic [255:0] digest_out   [3];
  logic         busy         [3];

  int n_checks = 0;
  int n_errors = 0;

  generate
    for (genvar g = 0; g < 3; g++) begin : g_dut
      sha256_core_multi #(.ROUNDS_PER_CYCLE(1 << g), .SUPPORT_224(1)) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .block_valid (block_valid[g]),
        .block_ready (block_ready[g]),
        .block_in    (block_in[g]),
        .block_init  (block_init[g]),
        .block_last  (block_last[g]),
        .mode_224    (mode_224[g]),
        .abort       (abort[g]),
        .digest_valid(digest_valid[g]),
        .digest_ready(digest_ready[g]),
        .digest_out  (digest_out[g]),
        .busy        (busy[g])
      );
    end
  endgenerate

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send(input int k, input logic [511:0] blk, input logic init, input logic last,
                      input logic m224, input string tag);
    int guard;
    guard = 0;
    while (!block_ready[k] && guard < 300) begin
      tick();
      guard++;
    end
    chk({tag, "_ready"}, 256'(block_ready[k]), 256'd1);
    block_in[k]    = blk;
    block_init[k]  = init;
    block_last[k]  = last;
    mode_224[k]    = m224;
    block_valid[k] = 1'b1;
    tick();
    block_valid[k] = 1'b0;
  endtask

  task automatic wait_digest(input int k, input int exp_lat, input string tag);
    int lat;
    lat = 0;
    while (!digest_valid[k] && lat < 300) begin
      @(posedge clk);
      lat++;
      #1;
    end
    chk({tag, "_lat"}, 256'(lat), 256'(exp_lat));
  endtask

  task automatic take_digest(input int k, input string tag);
    digest_ready[k] = 1'b1;
    tick();
    digest_ready[k] = 1'b0;
    chk({tag, "_dv_clear"}, 256'(digest_valid[k]), 256'd0);
    chk({tag, "_ready_back"}, 256'(block_ready[k]), 256'd1);
  endtask

  initial begin
    int  cnt;
    bit  saw_dv;
    bit  stable;
    int  lat_exp;
    string tag;

    for (int k = 0; k < 3; k++) begin
      block_valid[k]  = 1'b0;
      block_in[k]     = '0;
      block_init[k]   = 1'b0;
      block_last[k]   = 1'b0;
      mode_224[k]     = 1'b0;
      abort[k]        = 1'b0;
      digest_ready[k] = 1'b0;
    end
    rst_n = 1'b0;
    #3;
    chk("rst_ready",  256'(block_ready[0]),  256'd1);
    chk("rst_dv",     256'(digest_valid[0]), 256'd0);
    chk("rst_busy",   256'(busy[0]),         256'd0);
    chk("rst_digest", digest_out[0],         256'd0);
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    tick();

    // "abc" SHA-256 and SHA-224
    send(0, c_abc, 1'b1, 1'b1, 1'b0, "abc256");
    chk("abc256_busy", 256'(busy[0]), 256'd1);
    wait_digest(0, 65 + 1, "abc256");
    chk("abc256_digest", digest_out[0], c_d256);
    take_digest(0, "abc256");

    send(0, c_abc, 1'b1, 1'b1, 1'b1, "abc224");
    wait_digest(0, 66, "abc224");
    chk("abc224_digest", digest_out[0], c_d224);
    take_digest(0, "abc224");

    // Two-block message on each rounds-per-cycle variant
    for (int k = 0; k < 3; k++) begin
      lat_exp = 64 / (1 << k) + 2;
      tag = $sformatf("two_r%0d", 1 << k);
      send(k, c_two1, 1'b1, 1'b0, 1'b0, {tag, "_b1"});
      cnt = 0;
      saw_dv = 1'b0;
      while (!block_ready[k] && cnt < 300) begin
        @(posedge clk);
        cnt++;
        #1;
        if (digest_valid[k]) saw_dv = 1'b1;
      end
      chk({tag, "_b1_lat"}, 256'(cnt), 256'(lat_exp));
      chk({tag, "_b1_no_dv"}, 256'(saw_dv), 256'd0);
      send(k, c_two2, 1'b0, 1'b1, 1'b0, {tag, "_b2"});
      wait_digest(k, lat_exp, {tag, "_b2"});
      chk({tag, "_digest"}, digest_out[k], c_dtwo);
      take_digest(k, tag);
    end

    // Back-pressure in OUT with a pending block
    send(0, c_abc, 1'b1, 1'b1, 1'b0, "bp");
    wait_digest(0, 66, "bp");
    block_in[0] = c_abc; block_init[0] = 1'b1; block_last[0] = 1'b1; mode_224[0] = 1'b0;
    block_valid[0] = 1'b1;
    stable = 1'b1;
    repeat (20) begin
      tick();
      if (!(digest_valid[0] && digest_out[0] === c_d256 && !block_ready[0] && busy[0])) stable = 1'b0;
    end
    chk("bp_stable", 256'(stable), 256'd1);
    digest_ready[0] = 1'b1;
    tick();
    digest_ready[0] = 1'b0;
    chk("bp_hs_ready", 256'(block_ready[0]), 256'd1);
    chk("bp_hs_dv", 256'(digest_valid[0]), 256'd0);
    tick();
    block_valid[0] = 1'b0;
    chk("bp_accepted", 256'(busy[0]), 256'd1);
    wait_digest(0, 66, "bp_next");
    chk("bp_next_digest", digest_out[0], c_d256);
    take_digest(0, "bp_next");

    // Abort at COMP cycle 10 together with a new block
    send(0, c_abc, 1'b1, 1'b1, 1'b0, "abort");
    repeat (9) tick();
    abort[0] = 1'b1;
    block_valid[0] = 1'b1;
    tick();
    abort[0] = 1'b0;
    block_valid[0] = 1'b0;
    chk("abort_ready", 256'(block_ready[0]), 256'd1);
    chk("abort_dv", 256'(digest_valid[0]), 256'd0);
    chk("abort_busy", 256'(busy[0]), 256'd0);
    repeat (3) tick();
    chk("abort_dropped", 256'(busy[0]), 256'd0);
    send(0, c_abc, 1'b1, 1'b1, 1'b0, "post_abort");
    wait_digest(0, 66, "post_abort");
    chk("post_abort_digest", digest_out[0], c_d256);
    take_digest(0, "post_abort");

    // Asynchronous reset mid-COMP
    send(0, c_abc, 1'b1, 1'b1, 1'b0, "rstc");
    repeat (5) tick();
    #3;
    rst_n = 1'b0;
    #1;
    chk("rstc_ready",  256'(block_ready[0]),  256'd1);
    chk("rstc_busy",   256'(busy[0]),         256'd0);
    chk("rstc_dv",     256'(digest_valid[0]), 256'd0);
    chk("rstc_digest", digest_out[0],         256'd0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    tick();
    send(0, c_abc, 1'b1, 1'b1, 1'b0, "post_rstc");
    wait_digest(0, 66, "post_rstc");
    chk("post_rstc_digest", digest_out[0], c_d256);

    // Asynchronous reset mid-OUT
    repeat (2) tick();
    #3;
    rst_n = 1'b0;
    #1;
    chk("rsto_dv",     256'(digest_valid[0]), 256'd0);
    chk("rsto_ready",  256'(block_ready[0]),  256'd1);
    chk("rsto_digest", digest_out[0],         256'd0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    tick();
    send(0, c_abc, 1'b1, 1'b1, 1'b0, "post_rsto");
    wait_digest(0, 66, "post_rsto");
    chk("post_rsto_digest", digest_out[0], c_d256);
    take_digest(0, "post_rsto");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
